uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo_if
//  Purpose  : Pop-style handshake between a source FIFO and the UART transmitter.
//  Revision : 1.0
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int XLEN = 8
);
    logic            fifo_empty;
    logic [XLEN-1:0] fifo_do;
    logic            fifo_re;

    modport master (
        output fifo_empty,
        output fifo_do,
        input  fifo_re
    );

    modport slave (
        input  fifo_empty,
        input  fifo_do,
        output fifo_re
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : FIFO-fed UART transmitter, programmable baud divisor/parity/stop.
//  Revision : 1.0
// ============================================================================
module uart_tx #(
    parameter int XLEN      = 8,
    parameter int DIV_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 en,
    input  wire logic [DIV_WIDTH-1:0] divisor,
    input  wire logic                 parity_en,
    input  wire logic                 parity_odd,
    input  wire logic                 two_stop,
    uart_tx_fifo_if.slave             fifo,
    output logic                      tx,
    output logic                      busy
);
    localparam int                 c_BCW      = $clog2(XLEN + 1);
    localparam logic [c_BCW-1:0]   c_LAST_BIT = c_BCW'(XLEN - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [XLEN-1:0]      r_shift;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [c_BCW-1:0]     r_bitcnt;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic                 r_two_stop;
    logic                 r_stop2;
    logic                 r_tx;
    logic                 w_bit_end;
    logic                 w_last_stop;
    logic                 w_fifo_re;
    logic                 w_tx_next;

    assign w_bit_end   = (r_cnt == '0);
    assign w_last_stop = (r_state == c_STOP) && w_bit_end && (r_stop2 || !r_two_stop);
    assign fifo.fifo_re = w_fifo_re;
    assign tx           = r_tx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A pop always starts a new frame, whether from IDLE or the last stop cycle.
    always_comb begin
        w_next = r_state;
        if (w_fifo_re) begin
            w_next = c_START;
        end else begin
            case (r_state)
                c_START:  if (w_bit_end) w_next = c_DATA;
                c_DATA:   if (w_bit_end && (r_bitcnt == c_LAST_BIT))
                              w_next = r_par_en ? c_PARITY : c_STOP;
                c_PARITY: if (w_bit_end) w_next = c_STOP;
                c_STOP:   if (w_last_stop) w_next = c_IDLE;
                default:  w_next = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_fifo_re = reset && en && !fifo.fifo_empty &&
                    ((r_state == c_IDLE) || w_last_stop);
        busy      = (r_state != c_IDLE);
        w_tx_next = r_tx;
        if (w_fifo_re || ((r_state != c_IDLE) && w_bit_end)) begin
            case (w_next)
                c_START:  w_tx_next = 1'b0;
                c_DATA:   w_tx_next = (r_state == c_DATA) ? r_shift[1] : r_shift[0];
                c_PARITY: w_tx_next = r_par_bit;
                default:  w_tx_next = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift    <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            if (w_fifo_re) begin
                r_shift    <= fifo.fifo_do;
                r_div      <= divisor;
                r_cnt      <= divisor;
                r_bitcnt   <= '0;
                r_par_en   <= parity_en;
                r_par_bit  <= (^fifo.fifo_do) ^ parity_odd;
                r_two_stop <= two_stop;
                r_stop2    <= 1'b0;
            end else if (r_state != c_IDLE) begin
                if (w_bit_end) begin
                    r_cnt <= r_div;
                    if (r_state == c_DATA) begin
                        r_shift  <= r_shift >> 1;
                        r_bitcnt <= r_bitcnt + c_BCW'(1);
                    end
                    if (r_state == c_STOP) begin
                        r_stop2 <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - DIV_WIDTH'(1);
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Directed self-checking bench for uart_tx with a small model FIFO.
//  Revision : 1.0
// ============================================================================
module tb_uart_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] divisor;
    logic        parity_en, parity_odd, two_stop;
    logic        tx, busy;

    uart_tx_fifo_if #(.XLEN(8)) fif ();

    uart_tx #(.XLEN(8), .DIV_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .divisor    (divisor),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .fifo       (fif),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    int wr = 0;
    int rd = 0;
    int n_pops = 0;
    int cyc = 0;
    int viol = 0;
    int pop_t [64];

    assign fif.fifo_empty = (rd == wr);
    assign fif.fifo_do    = mem[rd % 16];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fif.fifo_re) begin
            if (rd == wr) viol <= viol + 1;
            rd             <= rd + 1;
            pop_t[n_pops % 64] <= cyc;
            n_pops         <= n_pops + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] act_v, exp_v;
    int exp_n;
    logic busy_last;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic        par_en;
        logic        par_odd;
        logic        two;
        string       bits;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr % 16] = d;
        wr++;
    endtask

    task automatic append_bit(input logic b, input int per);
        for (int p = 0; p < per; p++) begin
            exp_v[exp_n] = b;
            exp_n++;
        end
    endtask

    task automatic append_frame(input logic [7:0] d, input int per, input logic pe,
                                input logic po, input logic two);
        append_bit(1'b0, per);
        for (int b = 0; b < 8; b++) append_bit(d[b], per);
        if (pe) append_bit((^d) ^ po, per);
        append_bit(1'b1, per);
        if (two) append_bit(1'b1, per);
    endtask

    // kind 0: drop divisor to 0 at cycle chg_at; kind 1: drop en at cycle chg_at
    task automatic capture(input int n, input int chg_at, input int kind);
        act_v = '0;
        @(posedge clk);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            act_v[c] = tx;
            if (c == n - 1) busy_last = busy;
            if (c == chg_at) begin
                if (kind == 0) divisor = 16'd0;
                else           en = 1'b0;
            end
        end
    endtask

    task automatic set_cfg(input logic [15:0] d, input logic pe, input logic po, input logic two);
        divisor = d; parity_en = pe; parity_odd = po; two_stop = two;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;

        vecs[0] = '{8'h55, 16'd3, 1'b0, 1'b0, 1'b0, "0101010101"};
        vecs[1] = '{8'h07, 16'd0, 1'b1, 1'b0, 1'b1, "011100000111"};
        vecs[2] = '{8'hA1, 16'd1, 1'b1, 1'b1, 1'b0, "01000010101"};
        vecs[3] = '{8'h00, 16'd2, 1'b1, 1'b1, 1'b1, "000000000111"};
        vecs[4] = '{8'hFF, 16'd0, 1'b1, 1'b0, 1'b0, "01111111101"};
        vecs[5] = '{8'h3C, 16'd0, 1'b0, 1'b0, 1'b1, "00011110011"};

        // Reset with a word pending and en high: nothing may pop.
        reset = 1'b0; en = 1'b1;
        set_cfg(16'd2, 1'b0, 1'b0, 1'b0);
        push(8'hC3);
        repeat (3) @(negedge clk);
        chk("reset_tx", 128'(tx), 128'(1'b1));
        chk("reset_busy", 128'(busy), 128'(1'b0));
        chk("reset_fifo_re", 128'(fif.fifo_re), 128'(1'b0));
        chk("reset_no_pop", 128'(n_pops), 128'(0));
        reset = 1'b1;
        exp_v = '0; exp_n = 0;
        append_frame(8'hC3, 3, 1'b0, 1'b0, 1'b0);
        capture(exp_n, -1, 0);
        chk("post_reset_frame", act_v, exp_v);
        @(negedge clk);
        chk("post_reset_pops", 128'(n_pops), 128'(1));

        for (int i = 0; i < 6; i++) begin
            set_cfg(vecs[i].div, vecs[i].par_en, vecs[i].par_odd, vecs[i].two);
            base = n_pops;
            push(vecs[i].data);
            exp_v = '0; exp_n = 0;
            for (int b = 0; b < vecs[i].bits.len(); b++)
                append_bit(vecs[i].bits.getc(b) == 8'h31, int'(vecs[i].div) + 1);
            capture(exp_n, -1, 0);
            chk($sformatf("vec%0d_tx", i), act_v, exp_v);
            chk($sformatf("vec%0d_busy_last", i), 128'(busy_last), 128'(1'b1));
            @(negedge clk);
            chk($sformatf("vec%0d_idle", i), 128'({busy, tx}), 128'(2'b01));
            chk($sformatf("vec%0d_pops", i), 128'(n_pops - base), 128'(1));
        end

        // Back-to-back frames.
        set_cfg(16'd1, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        base = n_pops;
        push(8'hA1); push(8'h00); push(8'hFF);
        en = 1'b1;
        exp_v = '0; exp_n = 0;
        append_frame(8'hA1, 2, 1'b0, 1'b0, 1'b0);
        append_frame(8'h00, 2, 1'b0, 1'b0, 1'b0);
        append_frame(8'hFF, 2, 1'b0, 1'b0, 1'b0);
        capture(exp_n, -1, 0);
        chk("b2b_tx", act_v, exp_v);
        @(negedge clk);
        chk("b2b_pops", 128'(n_pops - base), 128'(3));
        chk("b2b_gap1", 128'(pop_t[(base + 1) % 64] - pop_t[base % 64]), 128'(20));
        chk("b2b_gap2", 128'(pop_t[(base + 2) % 64] - pop_t[(base + 1) % 64]), 128'(20));
        chk("b2b_idle", 128'(busy), 128'(1'b0));

        // Divisor change mid-DATA only affects the following frame.
        set_cfg(16'd3, 1'b0, 1'b0, 1'b0);
        base = n_pops;
        push(8'h55); push(8'h0F);
        exp_v = '0; exp_n = 0;
        append_frame(8'h55, 4, 1'b0, 1'b0, 1'b0);
        append_frame(8'h0F, 1, 1'b0, 1'b0, 1'b0);
        capture(exp_n, 10, 0);
        chk("divchg_tx", act_v, exp_v);
        @(negedge clk);
        chk("divchg_pops", 128'(n_pops - base), 128'(2));

        // en dropped mid-frame with a second word queued.
        set_cfg(16'd1, 1'b0, 1'b0, 1'b0);
        base = n_pops;
        push(8'h33); push(8'h44);
        exp_v = '0; exp_n = 0;
        append_frame(8'h33, 2, 1'b0, 1'b0, 1'b0);
        capture(exp_n, 6, 1);
        chk("endrop_tx", act_v, exp_v);
        repeat (10) @(negedge clk);
        chk("endrop_pops", 128'(n_pops - base), 128'(1));
        chk("endrop_idle", 128'({busy, tx}), 128'(2'b01));
        en = 1'b1;
        exp_v = '0; exp_n = 0;
        append_frame(8'h44, 2, 1'b0, 1'b0, 1'b0);
        capture(exp_n, -1, 0);
        chk("endrop_drain_tx", act_v, exp_v);
        @(negedge clk);
        chk("endrop_drain_pops", 128'(n_pops - base), 128'(2));

        // Asynchronous reset during PARITY.
        set_cfg(16'd3, 1'b1, 1'b0, 1'b0);
        base = n_pops;
        push(8'h12); push(8'h34);
        act_v = '0;
        @(posedge clk);
        for (int c = 0; c < 38; c++) @(negedge clk);
        chk("rstpar_parity_bit", 128'({busy, tx}), 128'(2'b10));
        #2 reset = 1'b0;
        #1;
        chk("rstpar_async", 128'({busy, tx, fif.fifo_re}), 128'(3'b010));
        repeat (3) @(negedge clk);
        chk("rstpar_no_pop", 128'(n_pops - base), 128'(1));
        reset = 1'b1;
        exp_v = '0; exp_n = 0;
        append_frame(8'h34, 4, 1'b1, 1'b0, 1'b0);
        n = exp_n;
        capture(n, -1, 0);
        chk("rstpar_resume_tx", act_v, exp_v);
        @(negedge clk);
        chk("rstpar_resume_pops", 128'(n_pops - base), 128'(2));

        chk("pop_while_empty", 128'(viol), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
